imem_loader: RTL
================

# imem_loader

Boot-time program loader that fills the CPU's 16-word instruction memory from a byte stream and then releases the core. It receives a framed image over a valid/ready byte interface: 16-bit word count, words high byte first, then an 8-bit checksum. It issues one 16-bit write per assembled word into the instruction-memory write port. The CPU's fetch path is held off (`cpu_hold`) until a complete image with a matching checksum has been loaded.

## Interface
- `DEPTH`, 16: number of instruction-memory words; legal word counts are 1..DEPTH.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle pulse; begins a load in IDLE, DONE or ERR; ignored while loading.
- `rx_data`  input  8  incoming image byte.
- `rx_valid`  input  1  `rx_data` valid.
- `rx_ready`  output  1  loader can accept a byte; a byte transfers on a cycle with `rx_valid && rx_ready`.
- `wr_en`  output  1  one-cycle instruction-memory write strobe.
- `wr_addr`  output  16  write word address, 0..DEPTH-1.
- `wr_data`  output  16  write word, `{hi_byte, lo_byte}`.
- `cpu_hold`  output  1  keeps the CPU in reset/stall; deasserted only in DONE.
- `done`  output  1  image loaded and checksum matched.
- `error`  output  1  illegal count or checksum mismatch.
- `word_count`  output  16  word count latched from the current/last header.

## Operation
- Frame: `CNT_HI`, `CNT_LO`, then N × (`W_HI`, `W_LO`), then `CSUM`. `CSUM` = 8-bit sum mod 256 of all 2N word bytes; count bytes are excluded.
- FSM states: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, CSUM, DONE, ERR.
- IDLE: `start` → CNT_HI. Clear the index and the running sum.
- CNT_HI: on accept, latch the high count byte → CNT_LO.
- CNT_LO: on accept, form the count and latch `word_count`.
  - Count is 0 or greater than DEPTH → ERR.
  - Otherwise → DAT_HI.
- DAT_HI: on accept, latch the high byte and add it to the sum → DAT_LO.
- DAT_LO: on accept, add the byte to the sum and register a write of `{hi, byte}` at the current index.
  - If the index equals count-1 → CSUM.
  - Otherwise increment the index → DAT_HI.
- CSUM: on accept, compare the byte with the running sum.
  - Equal → DONE.
  - Not equal → ERR.
- DONE: `done`=1, `cpu_hold`=0. `start` → CNT_HI, with `done`←0 and `cpu_hold`←1.
- ERR: `error`=1, `cpu_hold`=1. `start` → CNT_HI, with `error`←0.
- `rx_ready`=1 exactly in CNT_HI, CNT_LO, DAT_HI, DAT_LO and CSUM; 0 elsewhere. Bytes offered while not ready are not consumed.
- Words already written before an error stay written; the loader never erases them.
- Index width covers 0..DEPTH-1. `wr_addr` is the index zero-extended to 16 bits and never wraps.

## Timing
- Reset values (asynchronous): state IDLE, `cpu_hold`=1, `rx_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `done`=0, `error`=0, `word_count`=0, index=0, sum=0.
- Reset mid-load aborts immediately; no partial write strobe follows.
- Write latency: `wr_en`/`wr_addr`/`wr_data` are registered and valid the cycle after the DAT_LO accepting edge. `wr_en` is high for exactly one cycle.
- `wr_addr`/`wr_data` hold their last values while `wr_en`=0.
- Maximum throughput: one byte per cycle, so back-to-back writes occur at most every second cycle.
- `done`/`error` assert the cycle after the CSUM accept (or the CNT_LO accept for an illegal count).
- `done`/`error` stay asserted until `start` or reset.
- `rx_valid` may drop between any bytes; the FSM waits in its current state with no timeout.
- `start` while loading has no effect. `start` in the same cycle as a byte accept in IDLE is not possible, because `rx_ready`=0 in IDLE.

## Structure
- Shared package `cpu_pkg`: `loader_state_t` enum, `IMEM_DEPTH`=16, `WORD_W`=16, `BYTE_W`=8.
- Single module; no sub-module warranted. The checksum accumulator and word assembler are small enough to stay inline.

## Test plan
- Count 0x0003, words 0x1234, 0xABCD, 0x0001, CSUM 0xBF → writes (0,0x1234), (1,0xABCD), (2,0x0001); `done`=1, `cpu_hold`=0, `word_count`=3.
- Same frame with CSUM 0xC0 → all three writes still occur; then `error`=1, `done`=0, `cpu_hold`=1.
- Count 0x0011 (17) and count 0x0000 → `error`=1 one cycle after the second byte; no `wr_en`; `rx_ready`=0 afterwards.
- Full 16-word load with random `rx_valid` gaps → writes to addresses 0..15 in order, each `wr_en` exactly one cycle; `done`=1.
- Assert `rst_n`=0 after 5 bytes of a load → all outputs return to reset values asynchronously. A subsequent `start` plus the full frame loads correctly.
- Pulse `start` in DONE and in ERR → returns to CNT_HI, clears `done`/`error`, and `cpu_hold` goes to 1. Pulse `start` mid-load → no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the boot-time instruction-memory loader.
//   IMEM_DEPTH     : number of 16-bit words in the instruction memory
//   WORD_W/BYTE_W  : instruction word and stream byte widths
//   loader_state_t : loader FSM states, in frame order
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int IMEM_DEPTH = 16;
   localparam int WORD_W     = 16;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_HI,
      ST_CNT_LO,
      ST_DAT_HI,
      ST_DAT_LO,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_t;

endpackage : cpu_pkg

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's control, byte-stream, memory-write and status signals.
//   start                   : one-cycle load request
//   rx_data/rx_valid/rx_ready : byte stream handshake (transfer on valid&&ready)
//   wr_en/wr_addr/wr_data   : instruction-memory write port
//   cpu_hold/done/error     : core release and load status
//   word_count              : count taken from the latest frame header
// Modports:
//   master : the side that supplies the image and observes the results
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface imem_loader_if;
   import cpu_pkg::*;

   logic                start;
   logic [BYTE_W-1:0]   rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic                wr_en;
   logic [WORD_W-1:0]   wr_addr;
   logic [WORD_W-1:0]   wr_data;
   logic                cpu_hold;
   logic                done;
   logic                error;
   logic [WORD_W-1:0]   word_count;

   modport master (
      output start, rx_data, rx_valid,
      input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count
   );

endinterface : imem_loader_if

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills the CPU instruction memory from a framed byte stream and releases the
// core once a complete image with a matching checksum has arrived.
// Frame: CNT_HI, CNT_LO, N x (W_HI, W_LO), CSUM, where CSUM is the 8-bit sum
// of the 2N word bytes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imem_loader_if.slave (stream in, memory write port and status out)
// -----------------------------------------------------------------------------
module imem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH
) (
   input logic           clk,
   input logic           rst_n,
   imem_loader_if.slave  bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   loader_state_t        state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BYTE_W-1:0]    sum_q, sum_d;
   logic [BYTE_W-1:0]    hiByte_q, hiByte_d;
   logic [WORD_W-1:0]    wordCount_q, wordCount_d;
   logic                 wrEn_q, wrEn_d;
   logic [WORD_W-1:0]    wrAddr_q, wrAddr_d;
   logic [WORD_W-1:0]    wrData_q, wrData_d;

   logic                 rxReady;
   logic                 accept;
   logic [WORD_W-1:0]    cntFull;
   logic                 cntLegal;
   logic [WORD_W-1:0]    idxExt;
   logic                 lastWord;

   // The stream is only open while a frame is being parsed; every status
   // output is a pure function of the state so reset values fall out directly.
   always_comb begin
      rxReady = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                (state_q == ST_DAT_HI) || (state_q == ST_DAT_LO) ||
                (state_q == ST_CSUM);
   end

   assign accept          = bus.rx_valid && rxReady;
   assign bus.rx_ready    = rxReady;
   assign bus.done        = (state_q == ST_DONE);
   assign bus.error       = (state_q == ST_ERR);
   assign bus.cpu_hold    = (state_q != ST_DONE);
   assign bus.wr_en       = wrEn_q;
   assign bus.wr_addr     = wrAddr_q;
   assign bus.wr_data     = wrData_q;
   assign bus.word_count  = wordCount_q;

   // The high count byte is parked in hiByte_q while waiting for the low byte,
   // so one register serves both the header and the word assembler.
   assign cntFull  = {hiByte_q, bus.rx_data};
   assign cntLegal = (cntFull != '0) && (32'(cntFull) <= 32'(DEPTH));
   assign idxExt   = {{(WORD_W-IDX_W){1'b0}}, idx_q};
   assign lastWord = (idxExt == (wordCount_q - 16'd1));

   // State and datapath registers; reset drops any pending write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         sum_q       <= '0;
         hiByte_q    <= '0;
         wordCount_q <= '0;
         wrEn_q      <= 1'b0;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         hiByte_q    <= hiByte_d;
         wordCount_q <= wordCount_d;
         wrEn_q      <= wrEn_d;
         wrAddr_q    <= wrAddr_d;
         wrData_q    <= wrData_d;
      end
   end

   // Frame parser: one byte per accepted cycle, waiting indefinitely for
   // rx_valid. Restarting from DONE/ERR also clears the index and sum so a
   // second image starts from address 0 with a fresh checksum.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      hiByte_d    = hiByte_q;
      wordCount_d = wordCount_q;
      wrEn_d      = 1'b0;
      wrAddr_d    = wrAddr_q;
      wrData_d    = wrData_q;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start) begin
               state_d = ST_CNT_HI;
               idx_d   = '0;
               sum_d   = '0;
            end
         end

         ST_CNT_HI: begin
            if (accept) begin
               hiByte_d = bus.rx_data;
               state_d  = ST_CNT_LO;
            end
         end

         ST_CNT_LO: begin
            if (accept) begin
               wordCount_d = cntFull;
               state_d     = cntLegal ? ST_DAT_HI : ST_ERR;
            end
         end

         ST_DAT_HI: begin
            if (accept) begin
               hiByte_d = bus.rx_data;
               sum_d    = sum_q + bus.rx_data;
               state_d  = ST_DAT_LO;
            end
         end

         ST_DAT_LO: begin
            if (accept) begin
               sum_d    = sum_q + bus.rx_data;
               wrEn_d   = 1'b1;
               wrAddr_d = idxExt;
               wrData_d = {hiByte_q, bus.rx_data};
               if (lastWord) begin
                  state_d = ST_CSUM;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_DAT_HI;
               end
            end
         end

         ST_CSUM: begin
            if (accept) begin
               state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule : imem_loader
